decrypter: RTL and testbench

Receive-side counterpart of the link encrypter. Loads the shared key, accepts ciphertext words with their per-word rotation offset, and recovers plaintext as `dataIn ^ rotl(key, offset)`. Presents each result to the downstream consumer over a valid/acknowledge handshake. Sits between the link input (driven by an encrypter's `dataOut`/`dataRdyOut`) and the plaintext sink.

---
 rtl/decrypter.sv | 193 +++++++++++++++++++
 tb/tb_decrypter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decrypter                                                    |
// | Description : Receive-side link decrypter. Loads a shared key, accepts     |
// |               ciphertext words with a per-word rotation offset, recovers   |
// |               plaintext as dataIn ^ rotl(key, offset) and presents it over |
// |               a valid/acknowledge handshake.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decrypter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int ROT_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ROT_WIDTH-1:0]  rot_offset,
    input  logic                  dataRdyIn,
    input  logic                  prog,
    input  logic                  cap,
    input  logic                  dataAck,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rdyIn,
    output logic                  dataRdyOut,
    output logic [2:0]            state,
    output logic [KEY_WIDTH-1:0]  keyRotated,
    output logic [CNT_WIDTH-1:0]  wordCount
);

    localparam logic [2:0]  c_s_idle     = 3'b000;
    localparam logic [2:0]  c_s_load_key = 3'b001;
    localparam logic [2:0]  c_s_wait     = 3'b010;
    localparam logic [2:0]  c_s_decrypt  = 3'b011;
    localparam logic [2:0]  c_s_send     = 3'b100;
    localparam logic [31:0] c_key_w      = KEY_WIDTH;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;

    logic                   r_prog_q;
    logic                   r_cap_q;
    logic                   r_rdy_q;
    logic                   w_prog_rise;
    logic                   w_cap_rise;
    logic                   w_rdy_rise;

    logic [KEY_WIDTH-1:0]   r_key;
    logic                   r_key_valid;
    logic [DATA_WIDTH-1:0]  r_cipher;
    logic [ROT_WIDTH-1:0]   r_offset;

    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_rdy_in;
    logic                   r_data_rdy_out;
    logic [KEY_WIDTH-1:0]   r_key_rot;
    logic [CNT_WIDTH-1:0]   r_word_cnt;

    logic [31:0]            w_rot_amt;
    logic [2*KEY_WIDTH-1:0] w_key_dbl;
    logic [KEY_WIDTH-1:0]   w_key_rot;

    // Rising-edge detection against the previous-cycle samples
    assign w_prog_rise = prog & ~r_prog_q;
    assign w_cap_rise  = cap & ~r_cap_q;
    assign w_rdy_rise  = dataRdyIn & ~r_rdy_q;

    // True modular left rotation: shift a doubled key and keep the upper half
    assign w_rot_amt = 32'(r_offset) % c_key_w;
    assign w_key_dbl = {r_key, r_key} << w_rot_amt;
    assign w_key_rot = w_key_dbl[2*KEY_WIDTH-1 -: KEY_WIDTH];

    assign dataOut    = r_data_out;
    assign rdyIn      = r_rdy_in;
    assign dataRdyOut = r_data_rdy_out;
    assign state      = r_state;
    assign keyRotated = r_key_rot;
    assign wordCount  = r_word_cnt;

    // Input history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prog_q <= 1'b0;
            r_cap_q  <= 1'b0;
            r_rdy_q  <= 1'b0;
        end else begin
            r_prog_q <= prog;
            r_cap_q  <= cap;
            r_rdy_q  <= dataRdyIn;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; cap outranks prog, which outranks dataRdyIn, then dataAck
    always_comb begin
        w_state_nxt = r_state;
        if (w_cap_rise) begin
            w_state_nxt = r_key_valid ? c_s_wait : c_s_idle;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (w_prog_rise) w_state_nxt = c_s_load_key;
                end
                c_s_load_key: begin
                    w_state_nxt = c_s_wait;
                end
                c_s_wait: begin
                    if (w_prog_rise)     w_state_nxt = c_s_load_key;
                    else if (w_rdy_rise) w_state_nxt = c_s_decrypt;
                end
                c_s_decrypt: begin
                    if (w_prog_rise) w_state_nxt = c_s_load_key;
                    else             w_state_nxt = c_s_send;
                end
                c_s_send: begin
                    if (w_prog_rise)  w_state_nxt = c_s_load_key;
                    else if (dataAck) w_state_nxt = c_s_wait;
                end
                default: begin
                    w_state_nxt = c_s_idle;
                end
            endcase
        end
    end

    // Key, word capture, result and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key          <= '0;
            r_key_valid    <= 1'b0;
            r_cipher       <= '0;
            r_offset       <= '0;
            r_data_out     <= '0;
            r_rdy_in       <= 1'b0;
            r_data_rdy_out <= 1'b0;
            r_key_rot      <= '0;
            r_word_cnt     <= '0;
        end else if (w_cap_rise) begin
            // Drop any in-flight word; ready again only if a key is held
            r_data_rdy_out <= 1'b0;
            r_rdy_in       <= r_key_valid;
        end else begin
            case (r_state)
                c_s_load_key: begin
                    r_key       <= KEY_WIDTH'(dataIn);
                    r_key_valid <= 1'b1;
                    r_rdy_in    <= 1'b1;
                end
                c_s_wait: begin
                    if (w_prog_rise) begin
                        r_rdy_in <= 1'b0;
                    end else if (w_rdy_rise) begin
                        r_cipher <= dataIn;
                        r_offset <= rot_offset;
                        r_rdy_in <= 1'b0;
                    end
                end
                c_s_decrypt: begin
                    if (w_prog_rise) begin
                        r_data_rdy_out <= 1'b0;
                    end else begin
                        r_key_rot      <= w_key_rot;
                        r_data_out     <= r_cipher ^ DATA_WIDTH'(w_key_rot);
                        r_data_rdy_out <= 1'b1;
                    end
                end
                c_s_send: begin
                    if (w_prog_rise) begin
                        r_data_rdy_out <= 1'b0;
                    end else if (dataAck) begin
                        r_data_rdy_out <= 1'b0;
                        r_rdy_in       <= 1'b1;
                        r_word_cnt     <= r_word_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rdy_in <= r_rdy_in;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decrypter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decrypter                                                 |
// | Description : Self-checking bench for decrypter with a transaction-level   |
// |               reference model and randomized word traffic.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decrypter;

    localparam int         c_cnt_w  = 4;
    localparam int         c_cnt_m  = 16;
    localparam logic [2:0] c_idle   = 3'b000;
    localparam logic [2:0] c_load   = 3'b001;
    localparam logic [2:0] c_wait   = 3'b010;
    localparam logic [2:0] c_dec    = 3'b011;
    localparam logic [2:0] c_send   = 3'b100;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        dataIn;
    logic [4:0]         rot_offset;
    logic               dataRdyIn;
    logic               prog;
    logic               cap;
    logic               dataAck;
    logic [31:0]        dataOut;
    logic               rdyIn;
    logic               dataRdyOut;
    logic [2:0]         state;
    logic [31:0]        keyRotated;
    logic [c_cnt_w-1:0] wordCount;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: what the outputs must be after the most recent edge
    logic [2:0]  m_state = c_idle;
    logic        m_rdy   = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_rot   = '0;
    logic [31:0] m_key   = '0;
    logic        m_kv    = 1'b0;
    int          m_count = 0;

    decrypter #(
        .DATA_WIDTH (32),
        .KEY_WIDTH  (32),
        .ROT_WIDTH  (5),
        .CNT_WIDTH  (c_cnt_w)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .rot_offset (rot_offset),
        .dataRdyIn  (dataRdyIn),
        .prog       (prog),
        .cap        (cap),
        .dataAck    (dataAck),
        .dataOut    (dataOut),
        .rdyIn      (rdyIn),
        .dataRdyOut (dataRdyOut),
        .state      (state),
        .keyRotated (keyRotated),
        .wordCount  (wordCount)
    );

    always #5 clk = ~clk;

    // Bit-at-a-time left rotation
    function automatic logic [31:0] m_rotl(input logic [31:0] k, input int s);
        logic [31:0] r;
        r = k;
        for (int i = 0; i < (s % 32); i++) r = {r[30:0], r[31]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_state = c_idle;
        m_rdy   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_rot   = '0;
        m_key   = '0;
        m_kv    = 1'b0;
        m_count = 0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("state", 32'(state), 32'(m_state));
        check("rdyIn", 32'(rdyIn), 32'(m_rdy));
        check("dataRdyOut", 32'(dataRdyOut), 32'(m_valid));
        check("wordCount", 32'(wordCount), 32'(m_count));
        check("keyRotated", keyRotated, m_rot);
        if (m_valid) check("dataOut", dataOut, m_data);
    end

    task automatic load_key(input logic [31:0] k);
        prog   = 1'b1;
        dataIn = k;
        step;
        m_state = c_load;
        m_rdy   = 1'b0;
        m_valid = 1'b0;
        step;
        m_key   = k;
        m_kv    = 1'b1;
        m_rdy   = 1'b1;
        m_state = c_wait;
        prog    = 1'b0;
        dataIn  = $urandom;
        step;
    endtask

    task automatic cap_pulse;
        cap = 1'b1;
        step;
        m_valid = 1'b0;
        m_rdy   = m_kv;
        m_state = m_kv ? c_wait : c_idle;
        cap = 1'b0;
        step;
    endtask

    // mode 0: acknowledged, 1: aborted by cap, 2: aborted by key reload
    task automatic send_word(input logic [31:0] c, input int off, input int hold, input int mode,
                             input bit use_lit, input logic [31:0] lit_d, input logic [31:0] lit_r);
        dataIn     = c;
        rot_offset = 5'(off);
        dataRdyIn  = 1'b1;
        step;
        m_state = c_dec;
        m_rdy   = 1'b0;
        dataIn     = $urandom;
        rot_offset = 5'($urandom);
        step;
        m_state = c_send;
        m_valid = 1'b1;
        m_rot   = m_rotl(m_key, off);
        m_data  = c ^ m_rot;
        if (use_lit) begin
            check("lit_dataOut", dataOut, lit_d);
            check("lit_keyRotated", keyRotated, lit_r);
            check("lit_dataRdyOut", 32'(dataRdyOut), 32'd1);
        end
        repeat (hold) step;
        case (mode)
            0: begin
                dataAck = 1'b1;
                step;
                m_valid = 1'b0;
                m_rdy   = 1'b1;
                m_state = c_wait;
                m_count = (m_count + 1) % c_cnt_m;
                dataAck = 1'b0;
                step;
            end
            1: cap_pulse;
            default: load_key($urandom);
        endcase
        dataRdyIn = 1'b0;
        step;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int op;
        logic [31:0] w_cnt_before;
        reset = 1'b0; dataIn = '0; rot_offset = '0;
        dataRdyIn = 1'b0; prog = 1'b0; cap = 1'b0; dataAck = 1'b0;
        model_reset;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("reset_state", 32'(state), 32'(c_idle));
        check("reset_dataOut", dataOut, 32'h0);

        // Ciphertext before any key is ignored
        dataRdyIn = 1'b1;
        step;
        dataRdyIn = 1'b0;
        step;
        check("nokey_state", 32'(state), 32'(c_idle));
        check("nokey_rdyIn", 32'(rdyIn), 32'd0);

        // Known-answer words
        load_key(32'hA5A50F0F);
        check("key_rdyIn", 32'(rdyIn), 32'd1);
        send_word(32'h4864A682, 4, 0, 0, 1'b1, 32'h12345678, 32'h5A50F0FA);
        send_word(32'hA5A50F0F, 0, 0, 0, 1'b1, 32'h00000000, 32'hA5A50F0F);
        send_word(32'hD2D28787, 31, 5, 0, 1'b1, 32'h00000000, 32'hD2D28787);
        check("count_after3", 32'(wordCount), 32'd3);

        // Abort in SEND by cap keeps the count
        send_word($urandom, 7, 2, 1, 1'b0, '0, '0);
        check("cap_count", 32'(wordCount), 32'd3);
        check("cap_rdyIn", 32'(rdyIn), 32'd1);

        // Stray acknowledge outside SEND is ignored
        dataAck = 1'b1; step; dataAck = 1'b0; step;

        // Counter wrap with a fresh reset
        #2 reset = 1'b0;
        model_reset;
        dataRdyIn = 1'b0;
        step;
        reset = 1'b1;
        step;
        load_key($urandom);
        for (int i = 0; i < c_cnt_m; i++) begin
            send_word($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0, 1'b0, '0, '0);
            if (i == c_cnt_m - 2) check("count_15", 32'(wordCount), 32'd15);
        end
        check("count_wrap", 32'(wordCount), 32'd0);

        // Asynchronous reset while in DECRYPT
        dataIn = $urandom; rot_offset = 5'd3; dataRdyIn = 1'b1;
        step;
        m_state = c_dec;
        m_rdy   = 1'b0;
        #2 reset = 1'b0;
        model_reset;
        #1;
        check("arst_state", 32'(state), 32'(c_idle));
        check("arst_dataRdyOut", 32'(dataRdyOut), 32'd0);
        check("arst_keyRotated", keyRotated, 32'h0);
        check("arst_dataOut", dataOut, 32'h0);
        step;
        dataRdyIn = 1'b0;
        step;
        reset = 1'b1;
        step;
        dataRdyIn = 1'b1; step; dataRdyIn = 1'b0; step;
        check("arst_nokey_state", 32'(state), 32'(c_idle));
        check("arst_nokey_rdyIn", 32'(rdyIn), 32'd0);
        cap_pulse;
        check("cap_nokey_state", 32'(state), 32'(c_idle));

        // Randomized traffic
        load_key($urandom);
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 99));
            w_cnt_before = 32'(m_count);
            if (op < 45) begin
                send_word($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 0, 1'b0, '0, '0);
            end else if (op < 55) begin
                send_word($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1, 1'b0, '0, '0);
            end else if (op < 65) begin
                send_word($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 2, 1'b0, '0, '0);
            end else if (op < 80) begin
                load_key($urandom);
            end else if (op < 90) begin
                cap_pulse;
            end else begin
                dataAck = 1'b1; step; dataAck = 1'b0; step;
            end
            if (op >= 45) check("rand_count_hold", 32'(wordCount), w_cnt_before);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
